// File: rtl/secuenciador_contador_if.sv
// ---------------------------------------------------------------------------
// secuenciador_contador_if : control/address bundle between lab logic, sequencer and counter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface secuenciador_contador_if #(
   parameter int WIDTH = 12
);
   logic             START;
   logic             STOP;
   logic             STEP;
   logic             RESUME;
   logic [WIDTH-1:0] START_ADDR;
   logic [WIDTH-1:0] END_ADDR;
   logic [WIDTH-1:0] Y_CNT;
   logic             CNT_RESET;
   logic             CNT_LOAD;
   logic             CNT_ENABLE;
   logic [WIDTH-1:0] CNT_DLOAD;
   logic             BUSY;
   logic             DONE;

   modport master (
      output START, STOP, STEP, RESUME, START_ADDR, END_ADDR, Y_CNT,
      input  CNT_RESET, CNT_LOAD, CNT_ENABLE, CNT_DLOAD, BUSY, DONE
   );

   modport slave (
      input  START, STOP, STEP, RESUME, START_ADDR, END_ADDR, Y_CNT,
      output CNT_RESET, CNT_LOAD, CNT_ENABLE, CNT_DLOAD, BUSY, DONE
   );
endinterface

`default_nettype wire

// File: rtl/secuenciador_contador.sv
// ---------------------------------------------------------------------------
// secuenciador_contador : drives a loadable up-counter from START_ADDR to END_ADDR
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module secuenciador_contador #(
   parameter int WIDTH = 12
) (
   input  logic                   clk,
   input  logic                   RESET,
   secuenciador_contador_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_RUN   = 3'd2,
      S_PAUSE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] start_q;
   logic [WIDTH-1:0] end_q;
   logic             clr_q;

   logic [WIDTH-1:0] end_m1;
   logic             last_inc;
   logic             accept;
   logic             step_ok;

   assign end_m1   = end_q - WIDTH'(1);
   // Counter is one increment short of end_q: the coming increment finishes the run.
   assign last_inc = (bus.Y_CNT == end_m1);
   assign accept   = bus.START &&
                     ((state == S_IDLE) || (state == S_PAUSE) || (state == S_DONE));
   // START and STOP outrank STEP in PAUSE, so a step is suppressed when either is high.
   assign step_ok  = bus.STEP && !bus.START && !bus.STOP;

   always_ff @(posedge clk) begin
      if (RESET) begin
         state   <= S_IDLE;
         start_q <= '0;
         end_q   <= '0;
         clr_q   <= 1'b1;
      end else if (accept) begin
         state   <= S_LOAD;
         start_q <= bus.START_ADDR;
         end_q   <= bus.END_ADDR;
         clr_q   <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: state <= S_IDLE;
            S_LOAD: state <= (start_q == end_q) ? S_DONE : S_RUN;
            S_RUN: begin
               if (last_inc)
                  state <= S_DONE;
               else if (bus.STOP)
                  state <= S_PAUSE;
            end
            S_PAUSE: begin
               if (bus.STOP)
                  state <= S_PAUSE;
               else if (bus.STEP && last_inc)
                  state <= S_DONE;
               else if (bus.RESUME)
                  state <= S_RUN;
            end
            S_DONE: state <= S_DONE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.CNT_RESET  = clr_q;
   assign bus.CNT_LOAD   = (state == S_LOAD);
   assign bus.CNT_ENABLE = (state == S_RUN) || ((state == S_PAUSE) && step_ok);
   assign bus.CNT_DLOAD  = start_q;
   assign bus.BUSY       = (state == S_LOAD) || (state == S_RUN) || (state == S_PAUSE);
   assign bus.DONE       = (state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_secuenciador_contador.sv
// ---------------------------------------------------------------------------
// tb_secuenciador_contador : directed and random runs against an increment-count model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_secuenciador_contador;

   localparam int WIDTH = 12;
   localparam int MOD   = 4096;

   logic clk = 1'b0;
   logic RESET;

   always #5 clk = ~clk;

   secuenciador_contador_if #(.WIDTH(WIDTH)) bus ();

   secuenciador_contador #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .RESET (RESET),
      .bus   (bus)
   );

   // Behaviour of the team's counter the sequencer drives.
   logic [WIDTH-1:0] y_cnt;
   always_ff @(posedge clk) begin
      if (bus.CNT_RESET)
         y_cnt <= '0;
      else if (bus.CNT_LOAD)
         y_cnt <= bus.CNT_DLOAD;
      else if (bus.CNT_ENABLE)
         y_cnt <= y_cnt + 1'b1;
   end
   assign bus.Y_CNT = y_cnt;

   int n_assert = 0;
   int n_fail   = 0;

   // Model: a run is just "inc out of n increments done", plus a few flags.
   int m_start, m_end, m_n, m_inc, m_y;
   bit m_clr, m_active, m_pending, m_paused;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input bit rst, input bit st, input bit sp, input bit se,
                       input bit rs, input int sa, input int ea);
      bit e_done, e_run, e_en, e_busy;
      RESET          = rst;
      bus.START      = st;
      bus.STOP       = sp;
      bus.STEP       = se;
      bus.RESUME     = rs;
      bus.START_ADDR = sa[WIDTH-1:0];
      bus.END_ADDR   = ea[WIDTH-1:0];
      e_done = m_active && !m_pending && (m_inc == m_n);
      e_run  = m_active && !m_pending && !m_paused && (m_inc < m_n);
      e_en   = m_active && !m_pending && (m_inc < m_n) && (!m_paused || (se && !st && !sp));
      e_busy = m_pending || (m_active && !e_done);
      @(negedge clk);
      chk("cnt_reset",  32'(bus.CNT_RESET),  32'(m_clr));
      chk("cnt_load",   32'(bus.CNT_LOAD),   32'(m_pending));
      chk("cnt_enable", 32'(bus.CNT_ENABLE), 32'(e_en));
      chk("cnt_dload",  32'(bus.CNT_DLOAD),  32'(m_start));
      chk("busy",       32'(bus.BUSY),       32'(e_busy));
      chk("done",       32'(bus.DONE),       32'(e_done));
      @(posedge clk);
      if (m_clr)          m_y = 0;
      else if (m_pending) m_y = m_start;
      else if (e_en)      m_y = (m_y + 1) % MOD;
      if (rst) begin
         m_clr = 1; m_active = 0; m_pending = 0; m_paused = 0;
         m_start = 0; m_end = 0; m_n = 0; m_inc = 0;
      end else begin
         if (e_en) m_inc++;
         if (m_pending) begin
            m_pending = 0; m_inc = 0; m_paused = 0;
         end else if (st && (!m_active || m_paused || e_done)) begin
            m_start = sa; m_end = ea; m_n = (ea - sa + MOD) % MOD;
            m_pending = 1; m_active = 1; m_clr = 0;
         end else if (e_run && sp && (m_inc < m_n)) begin
            m_paused = 1;
         end else if (m_paused && !sp && rs) begin
            m_paused = 0;
         end
      end
      #1;
      chk("y", 32'(y_cnt), 32'(m_y));
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) tick(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic go(input int sa, input int ea);
      tick(0, 1, 0, 0, 0, sa, ea);
   endtask

   initial begin
      RESET = 1'b1;
      bus.START = 0; bus.STOP = 0; bus.STEP = 0; bus.RESUME = 0;
      bus.START_ADDR = '0; bus.END_ADDR = '0;
      m_clr = 1; m_active = 0; m_pending = 0; m_paused = 0;
      m_start = 0; m_end = 0; m_n = 0; m_inc = 0; m_y = 0;
      @(posedge clk);
      #1;

      // Reset state
      idle(3);
      chk("t1_y_zero", 32'(y_cnt), 32'h000);

      // Plain run 0x03C -> 0x046, then hold
      go('h03C, 'h046);
      idle(12);
      chk("t2_y_end", 32'(y_cnt), 32'h046);
      chk("t2_done", 32'(bus.DONE), 32'd1);
      idle(20);
      chk("t2_y_hold", 32'(y_cnt), 32'h046);

      // Pause at 0x040, three steps, resume
      go('h03C, 'h046);
      idle(5);
      chk("t3_y_040", 32'(y_cnt), 32'h040);
      tick(0, 0, 1, 0, 0, 0, 0);
      idle(3);
      chk("t3_y_paused", 32'(y_cnt), 32'h041);
      for (int i = 0; i < 3; i++) begin
         tick(0, 0, 0, 1, 0, 0, 0);
         idle(1);
      end
      chk("t3_y_steps", 32'(y_cnt), 32'h044);
      tick(0, 0, 0, 0, 1, 0, 0);
      idle(4);
      chk("t3_y_end", 32'(y_cnt), 32'h046);
      chk("t3_done", 32'(bus.DONE), 32'd1);

      // Wrap-around run
      go('hFFE, 'h002);
      idle(7);
      chk("t4_y_end", 32'(y_cnt), 32'h002);
      chk("t4_enable", 32'(bus.CNT_ENABLE), 32'd0);

      // Zero-length run
      go('h123, 'h123);
      idle(3);
      chk("t5_y", 32'(y_cnt), 32'h123);
      chk("t5_done", 32'(bus.DONE), 32'd1);

      // Reset mid-run at 0x042
      go('h03C, 'h046);
      idle(7);
      chk("t6_y_042", 32'(y_cnt), 32'h042);
      tick(1, 0, 0, 0, 0, 0, 0);
      idle(2);
      chk("t6_y_zero", 32'(y_cnt), 32'h000);

      // Random runs with random control pulses
      for (int r = 0; r < 40; r++) begin
         int sa;
         int ea;
         sa = int'($urandom_range(0, MOD - 1));
         ea = (sa + int'($urandom_range(0, 30))) % MOD;
         go(sa, ea);
         for (int c = 0; c < 45; c++) begin
            int p;
            bit rst, st, sp, se, rs;
            p  = int'($urandom_range(0, 99));
            rst = (p == 0);
            st  = ($urandom_range(0, 99) < 3);
            sp  = ($urandom_range(0, 99) < 10);
            se  = ($urandom_range(0, 99) < 30);
            rs  = ($urandom_range(0, 99) < 15);
            sa  = int'($urandom_range(0, MOD - 1));
            ea  = (sa + int'($urandom_range(0, 20))) % MOD;
            tick(rst, st, sp, se, rs, sa, ea);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
